// File: rtl/patgen_pkg.sv
// patgen_pkg: mode/state enums and the non-LFSR data-advance helper shared by
// bram_pattern_gen.
package patgen_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        PAT_CNT   = 2'd0,
        PAT_CONST = 2'd1,
        PAT_LFSR  = 2'd2,
        PAT_WALK  = 2'd3
    } pat_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Operates on a MAX_W container; w is the live data width (w <= MAX_W).
    // PAT_LFSR falls through to the counter here.
    function automatic logic [MAX_W-1:0] next_data(input pat_mode_e m,
                                                   input logic [MAX_W-1:0] d,
                                                   input int w);
        logic [MAX_W-1:0] mask;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        case (m)
            PAT_CONST: next_data = d;
            PAT_WALK:  next_data = ((d << 1) | (d >> (w - 1))) & mask;
            default:   next_data = (d + MAX_W'(1)) & mask;
        endcase
    endfunction

endpackage

// File: rtl/patgen_lfsr.sv
// patgen_lfsr: one combinational step of a right-shifting Galois LFSR whose
// feedback taps are LFSR_POLY.
module patgen_lfsr #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(32'h8020_0003)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    assign o_data = (i_data >> 1) ^ (i_data[0] ? LFSR_POLY : '0);

endmodule

// File: rtl/bram_pattern_gen.sv
// bram_pattern_gen: drives a native BRAM write port with a programmable pattern,
// rate and stride. Define PATGEN_LFSR_EN to build the LFSR pattern for mode 2.
module bram_pattern_gen
    import patgen_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(32'h8020_0003)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [1:0]               mode,
    input  logic                     oneshot,
    input  logic [15:0]              div,
    input  logic [$clog2(DEPTH)-1:0] incr,
    input  logic [DATA_W-1:0]        seed,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic [DATA_W-1:0]        bram_din,
    output logic                     bram_en,
    output logic [DATA_W/8-1:0]      bram_we,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              wrap_cnt
);

    localparam int                IDX_W   = $clog2(DEPTH);
    localparam int                WE_W    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BYTES   = ADDR_W'(WE_W);
    localparam logic [IDX_W:0]    DEPTH_X = (IDX_W + 1)'(DEPTH);

    state_e            r_state, w_state_nxt;
    pat_mode_e         r_mode, w_mode_in;
    logic              r_oneshot;
    logic [15:0]       r_div, r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]  r_incr, r_index, w_index_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt, w_seed_init, w_adv_data;
    logic [15:0]       r_wrap_cnt, w_wrap_nxt;
    logic              r_done, w_done_nxt, w_load;
    logic [IDX_W:0]    w_sum;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_en, r_busy;
    logic [WE_W-1:0]   r_we;

    assign w_mode_in = pat_mode_e'(mode);
    assign w_sum     = {1'b0, r_index} + {1'b0, r_incr};

    always_comb begin
        w_seed_init = seed;
        if (w_mode_in == PAT_WALK)
            w_seed_init = DATA_W'(1);
`ifdef PATGEN_LFSR_EN
        else if (w_mode_in == PAT_LFSR && seed == '0)
            w_seed_init = DATA_W'(1);
`endif
    end

`ifdef PATGEN_LFSR_EN
    logic [DATA_W-1:0] w_lfsr_data;

    patgen_lfsr #(
        .DATA_W    (DATA_W),
        .LFSR_POLY (LFSR_POLY)
    ) u_lfsr (
        .i_data (r_data),
        .o_data (w_lfsr_data)
    );

    assign w_adv_data = (r_mode == PAT_LFSR) ? w_lfsr_data
                                             : DATA_W'(next_data(r_mode, MAX_W'(r_data), DATA_W));
`else
    logic w_unused_poly;
    assign w_unused_poly = ^LFSR_POLY;
    assign w_adv_data    = DATA_W'(next_data(r_mode, MAX_W'(r_data), DATA_W));
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_index_nxt = r_index;
        w_data_nxt  = r_data;
        w_wrap_nxt  = r_wrap_cnt;
        w_done_nxt  = r_done;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_load      = 1'b1;
                    w_index_nxt = '0;
                    w_data_nxt  = w_seed_init;
                    w_wrap_nxt  = '0;
                    w_done_nxt  = 1'b0;
                    if (div == 16'd0) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = div;
                    end
                end
            end
            ST_WAIT: begin
                if (stop)
                    w_state_nxt = ST_IDLE;
                else if (r_cnt == 16'd1)
                    w_state_nxt = ST_WRITE;
                else
                    w_cnt_nxt = r_cnt - 16'd1;
            end
            ST_WRITE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_data_nxt  = w_adv_data;
                    w_state_nxt = (r_div == 16'd0) ? ST_WRITE : ST_WAIT;
                    w_cnt_nxt   = r_div;
                    // The sum is one bit wider than the index so a stride past the end is visible.
                    if (w_sum < DEPTH_X) begin
                        w_index_nxt = w_sum[IDX_W-1:0];
                    end else if (r_oneshot) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_index_nxt = IDX_W'(w_sum - DEPTH_X);
                        w_wrap_nxt  = (r_wrap_cnt == 16'hFFFF) ? r_wrap_cnt : r_wrap_cnt + 16'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobe outputs are loaded from the next-state decision so the registered
    // strobe lands in the same cycle the FSM sits in ST_WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= PAT_CNT;
            r_oneshot  <= 1'b0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_incr     <= '0;
            r_index    <= '0;
            r_data     <= '0;
            r_wrap_cnt <= '0;
            r_done     <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_en       <= 1'b0;
            r_we       <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_index    <= w_index_nxt;
            r_data     <= w_data_nxt;
            r_wrap_cnt <= w_wrap_nxt;
            r_done     <= w_done_nxt;
            if (w_load) begin
                r_mode    <= w_mode_in;
                r_oneshot <= oneshot;
                r_div     <= div;
                r_incr    <= (incr == '0) ? IDX_W'(1) : incr;
            end
            r_en   <= (w_state_nxt == ST_WRITE);
            r_we   <= (w_state_nxt == ST_WRITE) ? '1 : '0;
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_state_nxt == ST_WRITE) begin
                r_addr <= ADDR_W'(w_index_nxt) * BYTES;
                r_din  <= w_data_nxt;
            end
        end
    end

    assign bram_addr = r_addr;
    assign bram_din  = r_din;
    assign bram_en   = r_en;
    assign bram_we   = r_we;
    assign busy      = r_busy;
    assign done      = r_done;
    assign wrap_cnt  = r_wrap_cnt;

endmodule
